// File: rtl/day_07_row_sequencer_if.sv
// ---------------------------------------------------------------------------
// day_07_row_sequencer_if
// Purpose : bundles the splitter-RAM read port and the row valid/ready
//           stream that the Day 7 row sequencer drives toward the beam core.
// Signals :
//   mem_addr  - registered block RAM read address (sequencer -> RAM)
//   mem_data  - RAM read data, valid one cycle after mem_addr (RAM -> sequencer)
//   row_data  - assembled ROW_BITS-wide splitter mask
//   row_valid - row_data/row_index/row_last are valid
//   row_ready - consumer accepts the presented row
//   row_index - row number of the presented row
//   row_last  - presented row is the final row
// Modports: master = sequencer side, slave = RAM + beam-core side.
// ---------------------------------------------------------------------------
interface day_07_row_sequencer_if #(
  parameter int ROW_BITS = 141,
  parameter int ADDR_W   = 10
);
  logic [ADDR_W-1:0]   mem_addr;
  logic [15:0]         mem_data;
  logic [ROW_BITS-1:0] row_data;
  logic                row_valid;
  logic                row_ready;
  logic [6:0]          row_index;
  logic                row_last;

  modport master (
    output mem_addr,
    input  mem_data,
    output row_data,
    output row_valid,
    input  row_ready,
    output row_index,
    output row_last
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    input  row_data,
    input  row_valid,
    output row_ready,
    input  row_index,
    input  row_last
  );
endinterface

// File: rtl/day_07_row_sequencer.sv
// ---------------------------------------------------------------------------
// day_07_row_sequencer
// Purpose : walks the Day 7 splitter block RAM (ROWS x WORDS_PER_ROW 16-bit
//           words), packs each row into one ROW_BITS-wide mask and hands it
//           to the beam-propagation datapath over a valid/ready handshake.
//           Owns the RAM address and row counters; raises done once every
//           row has been accepted.
// Ports   :
//   clk            - single clock
//   rst            - synchronous active-high reset
//   start_i        - one-cycle pulse, begins or restarts a pass from row 0
//   bus            - day_07_row_sequencer_if.master (RAM port + row stream)
//   busy_o         - a pass is in progress (FETCH or PRESENT)
//   done_o         - all rows accepted, held until start_i or rst
//   stall_cycles_o - saturating count of valid && !ready cycles
//                    (only when ROW_STALL_COUNT_EN is defined)
// Config  : `define ROW_STALL_COUNT_EN to add the stall counter and its port.
// ---------------------------------------------------------------------------
module day_07_row_sequencer #(
  parameter int ROWS          = 70,
  parameter int WORDS_PER_ROW = 9,
  parameter int ROW_BITS      = 141,
  parameter int ADDR_W        = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  day_07_row_sequencer_if.master       bus,
`ifdef ROW_STALL_COUNT_EN
  output logic [15:0]                  stall_cycles_o,
`endif
  output logic                         busy_o,
  output logic                         done_o
);

  // Words 0..WORDS_PER_ROW-2 are kept whole; only the low LAST_BITS of the
  // final word of a row carry mask bits.
  localparam int ASM_W     = 16 * (WORDS_PER_ROW - 1);
  localparam int LAST_BITS = ROW_BITS - ASM_W;
  localparam int CNT_W     = $clog2(WORDS_PER_ROW + 1);

  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(WORDS_PER_ROW - 1);
  localparam logic [CNT_W-1:0] LAST_CAPT  = CNT_W'(WORDS_PER_ROW);
  localparam logic [6:0]       LAST_ROW   = 7'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [6:0]          row_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ASM_W-1:0]    asm_q;
  logic [ROW_BITS-1:0] row_data_q;
  logic                valid_q;
  logic                last_q;
  logic                busy_q;
  logic                done_q;

  logic [ROW_BITS-1:0] row_data_d;
  logic                last_d;

  // Final word of the row is concatenated with the already-assembled
  // words; its bits above ROW_BITS are simply not taken.
  assign row_data_d = {bus.mem_data[LAST_BITS-1:0], asm_q};
  assign last_d     = (row_q == LAST_ROW);

  // cnt_q runs 0..WORDS_PER_ROW during FETCH. It doubles as the issue
  // index (address advances while cnt_q < WORDS_PER_ROW-1) and, offset by
  // one cycle of RAM latency, as the capture index (word cnt_q-1 arrives).
  // The address therefore stops on the last word of the row and the next
  // row base is simply addr_q + 1, so it never passes the final RAM word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      row_data_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (start_i) begin
      state_q <= FETCH;
      addr_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q < LAST_ISSUE) begin
            addr_q <= addr_q + 1'b1;
          end
          if (cnt_q == LAST_CAPT) begin
            row_data_q <= row_data_d;
            valid_q    <= 1'b1;
            last_q     <= last_d;
            state_q    <= PRESENT;
          end else if (cnt_q != '0) begin
            asm_q <= {bus.mem_data, asm_q[ASM_W-1:16]};
          end
        end
        PRESENT: begin
          if (bus.row_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              row_q   <= row_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              cnt_q   <= '0;
              state_q <= FETCH;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ROW_STALL_COUNT_EN
  logic [15:0] stall_q;

  // Counts presented-but-not-accepted cycles, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst || start_i) begin
      stall_q <= '0;
    end else if (valid_q && !bus.row_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

  assign bus.mem_addr  = addr_q;
  assign bus.row_data  = row_data_q;
  assign bus.row_valid = valid_q;
  assign bus.row_index = row_q;
  assign bus.row_last  = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_day_07_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_day_07_row_sequencer
// Purpose : self-checking bench for day_07_row_sequencer. Models the block
//           RAM with one cycle of read latency and drives directed vectors.
// ---------------------------------------------------------------------------
module tb_day_07_row_sequencer;

  localparam int ROWS     = 70;
  localparam int WPR      = 9;
  localparam int ROW_BITS = 141;
  localparam int ADDR_W   = 10;

  logic clk = 1'b0;
  logic rst;
  logic startPulse;
  logic busy;
  logic done;
`ifdef ROW_STALL_COUNT_EN
  logic [15:0] stallCycles;
`endif

  int compares = 0;
  int failures = 0;

  logic [15:0] ram [0:1023];

  typedef struct {
    logic [15:0]         lastWord;
    logic [15:0]         otherWord;
    logic [ROW_BITS-1:0] expData;
  } vec_t;

  vec_t vecs [4];
  logic [ROW_BITS-1:0] row0Lit;

  always #5 clk = ~clk;

  day_07_row_sequencer_if #(.ROW_BITS(ROW_BITS), .ADDR_W(ADDR_W)) bus ();

  // Synchronous-read RAM: data for the address seen at an edge appears
  // after that edge.
  always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];

  day_07_row_sequencer #(
    .ROWS(ROWS), .WORDS_PER_ROW(WPR), .ROW_BITS(ROW_BITS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(startPulse),
    .bus(bus),
`ifdef ROW_STALL_COUNT_EN
    .stall_cycles_o(stallCycles),
`endif
    .busy_o(busy),
    .done_o(done)
  );

  // Compares one observed value against its required value.
  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    compares++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Drives inputs, then advances one clock edge and settles 1 time unit.
  task automatic applyStimulus(input logic s, input logic rdy, input logic r);
    startPulse    = s;
    bus.row_ready = rdy;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  // Expected mask for row r from the RAM image.
  function automatic logic [ROW_BITS-1:0] expRow(input int r);
    logic [16*WPR-1:0] tmp;
    for (int k = 0; k < WPR; k++) tmp[16*k +: 16] = ram[r*WPR + k];
    return tmp[ROW_BITS-1:0];
  endfunction

  initial begin
    int rowCnt;
    int maxAddr;
    int acceptCount;
    int firstT;
    logic found;

    for (int a = 0; a < 1024; a++) ram[a] = 16'(a);

    vecs[0] = '{16'hFFFF, 16'h0000, {13'h1FFF, 128'h0}};
    vecs[1] = '{16'h0000, 16'hFFFF, {13'h0000, {8{16'hFFFF}}}};
    vecs[2] = '{16'hE000, 16'h0000, {ROW_BITS{1'b0}}};
    vecs[3] = '{16'h1234, 16'hA5A5, {13'h1234, {8{16'hA5A5}}}};
    row0Lit = {13'h008, 16'h0007, 16'h0006, 16'h0005, 16'h0004,
               16'h0003, 16'h0002, 16'h0001, 16'h0000};

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_addr",  192'(bus.mem_addr),  192'(0));
    checkOutput("rst_valid", 192'(bus.row_valid), 192'(0));
    checkOutput("rst_data",  192'(bus.row_data),  192'(0));
    checkOutput("rst_index", 192'(bus.row_index), 192'(0));
    checkOutput("rst_last",  192'(bus.row_last),  192'(0));
    checkOutput("rst_busy",  192'(busy),          192'(0));
    checkOutput("rst_done",  192'(done),          192'(0));
`ifdef ROW_STALL_COUNT_EN
    checkOutput("rst_stall", 192'(stallCycles),   192'(0));
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Truncation / packing table on row 0
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < WPR-1; k++) ram[k] = vecs[i].otherWord;
      ram[WPR-1] = vecs[i].lastWord;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("tbl_valid_early", 192'(bus.row_valid), 192'(0));
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("tbl_valid", 192'(bus.row_valid), 192'(1));
      checkOutput("tbl_data",  192'(bus.row_data),  192'(vecs[i].expData));
      checkOutput("tbl_index", 192'(bus.row_index), 192'(0));
      checkOutput("tbl_last",  192'(bus.row_last),  192'(0));
    end
    for (int a = 0; a < WPR; a++) ram[a] = 16'(a);

    // Full pass with row_ready tied high
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pass_busy0", 192'(busy),         192'(1));
    checkOutput("pass_addr0", 192'(bus.mem_addr), 192'(0));
    rowCnt  = 0;
    maxAddr = 0;
    for (int t = 1; t <= 775; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (int'(bus.mem_addr) > maxAddr) maxAddr = int'(bus.mem_addr);
      if (bus.row_valid) begin
        if (rowCnt < ROWS) begin
          checkOutput("pass_time",  192'(t),             192'(11*rowCnt + 10));
          checkOutput("pass_index", 192'(bus.row_index), 192'(rowCnt));
          checkOutput("pass_last",  192'(bus.row_last),  192'(rowCnt == ROWS-1));
          checkOutput("pass_data",  192'(bus.row_data),  192'(expRow(rowCnt)));
          if (rowCnt == 0) checkOutput("pass_row0_lit", 192'(bus.row_data), 192'(row0Lit));
        end
        rowCnt++;
      end
      if (t == 769) begin
        checkOutput("pass_done_769", 192'(done), 192'(0));
        checkOutput("pass_busy_769", 192'(busy), 192'(1));
      end
      if (t == 770) begin
        checkOutput("pass_done_770", 192'(done), 192'(1));
        checkOutput("pass_busy_770", 192'(busy), 192'(0));
      end
    end
    checkOutput("pass_rows",    192'(rowCnt),       192'(ROWS));
    checkOutput("pass_maxaddr", 192'(maxAddr),      192'(629));

    // Done hold while row_ready toggles
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, (i % 2) == 1, 1'b0);
      checkOutput("hold_done",  192'(done),          192'(1));
      checkOutput("hold_valid", 192'(bus.row_valid), 192'(0));
      checkOutput("hold_addr",  192'(bus.mem_addr),  192'(629));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("restart_done", 192'(done),         192'(0));
    checkOutput("restart_busy", 192'(busy),         192'(1));
    checkOutput("restart_addr", 192'(bus.mem_addr), 192'(0));

    // Backpressure on row 3 for 25 cycles
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.row_valid && bus.row_index == 7'd3) found = 1'b1;
    end
    checkOutput("bp_found", 192'(found), 192'(1));
    if (found) begin
      for (int i = 0; i < 25; i++) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bp_valid", 192'(bus.row_valid), 192'(1));
        checkOutput("bp_index", 192'(bus.row_index), 192'(3));
        checkOutput("bp_data",  192'(bus.row_data),  192'(expRow(3)));
      end
      acceptCount = 0;
      for (int t = 0; t < 30; t++) begin
        if (bus.row_valid && bus.row_index == 7'd3) acceptCount++;
        applyStimulus(1'b0, 1'b1, 1'b0);
      end
      checkOutput("bp_accepts", 192'(acceptCount), 192'(1));
`ifdef ROW_STALL_COUNT_EN
      checkOutput("bp_stall", 192'(stallCycles), 192'(25));
`endif
    end

    // Restart while presenting row 5
    applyStimulus(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.row_valid && bus.row_index == 7'd5) found = 1'b1;
    end
    checkOutput("rs_found", 192'(found), 192'(1));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rs_valid", 192'(bus.row_valid), 192'(0));
    checkOutput("rs_addr",  192'(bus.mem_addr),  192'(0));
    checkOutput("rs_busy",  192'(busy),          192'(1));
`ifdef ROW_STALL_COUNT_EN
    checkOutput("rs_stall", 192'(stallCycles), 192'(0));
`endif
    firstT = -1;
    for (int t = 1; t <= 20 && firstT < 0; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.row_valid) begin
        firstT = t;
        checkOutput("rs_index", 192'(bus.row_index), 192'(0));
      end
    end
    checkOutput("rs_first_time", 192'(firstT), 192'(10));

    // rst and start together during FETCH of row 10
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (111) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rp_pre_index", 192'(bus.row_index), 192'(10));
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rp_busy",  192'(busy),          192'(0));
    checkOutput("rp_done",  192'(done),          192'(0));
    checkOutput("rp_valid", 192'(bus.row_valid), 192'(0));
    checkOutput("rp_addr",  192'(bus.mem_addr),  192'(0));
    checkOutput("rp_data",  192'(bus.row_data),  192'(0));
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("rp_idle", 192'({bus.row_valid, busy, bus.mem_addr}), 192'(0));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    firstT = -1;
    for (int t = 1; t <= 20 && firstT < 0; t++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.row_valid) begin
        firstT = t;
        checkOutput("rp_after_index", 192'(bus.row_index), 192'(0));
      end
    end
    checkOutput("rp_after_time", 192'(firstT), 192'(10));

    $display("End of test - %0d assertions evaluated, %0d failures", compares, failures);
    $finish;
  end

endmodule

// File: doc/day_07_row_sequencer.md
# day_07_row_sequencer

Sequencer that walks the Day 7 splitter block RAM (`ROWS` rows × `WORDS_PER_ROW` 16-bit words, 70 × 9 = 630 words) and turns each row of packed words into one `ROW_BITS`-wide splitter mask. It presents each mask to the beam-propagation datapath over a valid/ready handshake. It owns the RAM address counter and the row counter, and it signals `done` when every row has been consumed. The beam core then only has to combine each mask with its `active` vector and does not do any address arithmetic.

## Interface
- `ROWS`, 70, number of splitter rows in RAM
- `WORDS_PER_ROW`, 9, 16-bit words per row
- `ROW_BITS`, 141, valid mask bits per row (≤ 16·`WORDS_PER_ROW`)
- `ADDR_W`, 10, RAM address width
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset
- `start` in 1: one-cycle pulse that begins or restarts a pass
- `mem_addr` out `ADDR_W`: registered address to the block RAM
- `mem_data` in 16: RAM read data, valid one cycle after `mem_addr`
- `row_data` out `ROW_BITS`: assembled splitter mask
- `row_valid` out 1: `row_data`/`row_index`/`row_last` are valid
- `row_ready` in 1: consumer accepts the row
- `row_index` out 7: row number of the presented row
- `row_last` out 1: presented row is `ROWS-1`
- `busy` out 1: state ≠ IDLE/DONE
- `done` out 1: all rows accepted; held until `start` or `rst`
- `stall_cycles` out 16: present only with `ROW_STALL_COUNT_EN`

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- **Reset values:** every output is 0, and `row_data` is all zeros. The sequencer enters IDLE.
- **IDLE / DONE:** on `start`, set row = 0, `mem_addr` = 0, word = 0, clear `done`, and go to FETCH.
- **FETCH:**
  - `mem_addr` advances by 1 each cycle through `row·WORDS_PER_ROW + k`, for k = 0..`WORDS_PER_ROW-1`.
  - Each cycle the sequencer captures `mem_data` for word k into bits [16k+15:16k] of an internal shift/assembly register.
  - Bits at or above `ROW_BITS` are discarded, so only the low 13 bits of word 8 are used.
  - After the last word is captured, it asserts `row_valid` and goes to PRESENT.
- **PRESENT:**
  - `row_data`, `row_index` and `row_last` are held stable while `row_valid && !row_ready`.
  - On accept (`row_valid && row_ready`), `row_valid` drops the next cycle.
  - If `row_last` was set, go to DONE and set `done`.
  - Otherwise, increment row, set `mem_addr` to the new row base, and go to FETCH.
- **`row_valid` never depends combinationally on `row_ready`.**
- **Address rules:** `mem_addr` never exceeds `ROWS·WORDS_PER_ROW-1` (629). It holds its last value in DONE.
- **`start` in any state:** aborts the pass and restarts from row 0. A row being presented is dropped, and `row_valid` is low the cycle after.
- **`rst` and `start` in the same cycle:** `rst` wins and the sequencer goes to IDLE.
- **`rst` mid-pass:** the sequencer goes to IDLE with all outputs at their reset values and no further RAM reads.

## Timing
- Let E be the edge that samples `start`, or the edge that accepts a non-last row.
  - After edge E, `mem_addr` = row base.
  - Word k is captured at edge E+2+k.
  - `row_valid` is high after edge E+10, i.e. E+1+`WORDS_PER_ROW`.
- With `row_ready` tied high:
  - row r is accepted at edge 11·(r+1) after the `start` edge;
  - `done` rises after edge 770 for 70 rows.
- There is no overlap between fetching and presenting. This is the one-row-in-flight throughput, 11 cycles per row.
- `busy` is high from the edge after `start` until the edge that sets `done`.

## Configuration
- **`ROW_STALL_COUNT_EN` defined:**
  - adds the `stall_cycles` output, which counts cycles with `row_valid && !row_ready`;
  - the counter saturates at 0xFFFF;
  - it clears on `start` and `rst`, and holds in DONE.
- **`ROW_STALL_COUNT_EN` undefined:** the `stall_cycles` port and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Full pass:** RAM word at address a = a; `row_ready` = 1; pulse `start`.
  - Row 0 `row_data` = {13'h008, 16'h0007, …, 16'h0000}.
  - `row_valid` first rises 10 cycles after the `start` edge.
  - `row_last` is set only on `row_index` = 69.
  - `done` rises at edge 770; `mem_addr` max = 629.
- **Backpressure:** hold `row_ready` = 0 for 25 cycles on row 3.
  - `row_data` and `row_index` are stable throughout; row 3 is accepted exactly once.
  - With `ROW_STALL_COUNT_EN`, `stall_cycles` = 25.
- **Truncation:** row 0, word 8 = 16'hFFFF and all other words 0.
  - `row_data` = 13 ones in bits [140:128] and zeros elsewhere.
- **Restart mid-pass:** pulse `start` while presenting row 5.
  - `row_valid` is low the next cycle.
  - `mem_addr` returns to 0.
  - The next presented row has `row_index` = 0.
- **Reset priority:** assert `rst` and `start` together during FETCH of row 10.
  - The sequencer is in IDLE; `busy`, `done`, `row_valid` and `mem_addr` are all 0.
  - No row is presented until a later `start`.
- **Done hold:** after `done`, toggle `row_ready` for 50 cycles.
  - `done` stays 1, `row_valid` stays 0, `mem_addr` stays 629.
  - A new `start` clears `done` the next cycle.
